dec_stage_pipe: RTL and testbench
=================================

# dec_stage_pipe

Parametrised, pipelined decode stage for the MIPS-style datapath. It holds the register file, performs write-back data selection and immediate generation, and captures the decoded operands into an ID/EX pipeline register. The register has valid, stall and flush control. An optional write-to-read bypass keeps operands coherent with same-cycle and stalled-cycle write-backs.

## Interface
- DATA_W, 32: register, operand and immediate width; legal range 16..64.
- REG_CNT, 32: number of architectural registers; legal range 2..32. Addresses are always 5 bits wide.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  32  instruction word. Fields: rs=[25:21], rd=[20:16], rt=[15:11], imm=[15:0].
- Instr_valid  in  1  Instr carries a real instruction.
- Stall  in  1  hold the ID/EX register.
- Flush  in  1  insert a bubble into the ID/EX register.
- RF_B_sel  in  1  second read address: 0 selects rt, 1 selects rd.
- Imm_sel  in  2  immediate mode (see Operation).
- RF_WrEn  in  1  write-back enable.
- RF_WrAddr  in  5  write-back destination.
- ALU_out  in  DATA_W  write-back candidate 0.
- MEM_out  in  DATA_W  write-back candidate 1.
- RF_WrData_sel  in  1  0 selects ALU_out, 1 selects MEM_out.
- RF_A  out  DATA_W  registered rs operand.
- RF_B  out  DATA_W  registered second operand.
- Immed  out  DATA_W  registered immediate.
- Rd_out  out  5  registered Instr[20:16].
- Valid_out  out  1  ID/EX register holds a valid instruction.

## Operation
- Write-back data: WrData = RF_WrData_sel ? MEM_out : ALU_out.
- Register write: on a rising edge with RF_WrEn=1, WrAddr≠0 and WrAddr<REG_CNT, the register is written. All other writes are dropped.
- Register 0 always reads 0. Any address ≥REG_CNT reads 0.
- Immediate modes (imm=Instr[15:0]):
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: imm<<16, zero-filled.
  - 11: sign-extend then <<2.
  - Results are computed at DATA_W+2 and truncated to DATA_W.
- ID/EX update, in priority order:
  - Flush=1: Valid_out←0 and all data outputs←0.
  - Else Stall=1: hold all outputs, subject to the bypass refresh below.
  - Else: capture RF_A, RF_B, Immed and Rd_out; Valid_out←Instr_valid. A bubble (Instr_valid=0) still captures data.
- Flush and Stall together: the flush wins.
- Source addresses (rs and the selected second address) are captured alongside the operands for use by the bypass.

## Timing
- Reset (asynchronous): all outputs 0 and all registers 0, effective immediately without waiting for Clk.
- Deasserting Reset mid-operation requires no recovery sequence. The first edge after deassertion behaves normally.
- Latency: Instr to outputs in 1 cycle. The register file itself is read combinationally.
- A write-back committed at edge N is visible to reads of an instruction captured at edge N+1 or later, in all configurations.
- A write to register 0 or to an out-of-range address has no effect and is never bypassed.

## Configuration
- DEC_BYPASS_EN defined:
  - Capture: if RF_WrEn=1 and WrAddr matches a non-zero, in-range source address on the capturing edge, that operand captures WrData rather than the stale register value.
  - Stall: while Stall=1 (and Flush=0), a write-back that matches a held source address also refreshes the held RF_A/RF_B on that edge.
  - If both sources match, both are updated.
- DEC_BYPASS_EN undefined:
  - Operands capture the pre-write register contents.
  - Held operands never change during a stall.
  - Software must separate dependent instructions by one slot.

## Structure
- Package dec_pkg holds:
  - Imm_sel encodings: IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BR.
  - Field LSB constants: RS_LSB=21, RD_LSB=16, RT_LSB=11.
  - ADDR_W=5.
- Sub-module dec_regfile(DATA_W, REG_CNT):
  - 2 combinational read ports and 1 synchronous write port.
  - Asynchronous reset, register 0 forced to zero.
- Top level contains the write-data mux, immediate generation, the ID/EX register and the bypass compare.

## Test plan
- Reset asserted mid-cycle while Valid_out=1 -> all outputs 0 immediately, before the next Clk edge.
- Write 7 to r1 and 5 to r2 via ALU_out, then Instr with rs=1, rt=2, RF_B_sel=0, Instr_valid=1 -> next cycle RF_A=7, RF_B=5, Valid_out=1.
- MEM_out=12, RF_WrData_sel=1, write r3 on the same edge that an instruction with rs=3 is captured:
  - With DEC_BYPASS_EN: RF_A=12.
  - Without DEC_BYPASS_EN: RF_A=0; the following cycle re-read gives 12.
- Stall held for 3 cycles while r1 is written with 9, then released:
  - With DEC_BYPASS_EN: RF_A updates to 9 during the stall.
  - Without DEC_BYPASS_EN: RF_A stays 7.
  - In both configurations Immed and Rd_out stay constant.
- imm=0x8001 in each Imm_sel mode, DATA_W=32 -> 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004. Write to r0 -> r0 still reads 0.
- Flush and Stall asserted together -> Valid_out=0 and data outputs 0. With REG_CNT=16, a write to r20 is ignored and reading r20 returns 0.

Source files
------------

// File: rtl/dec_pkg.sv
// ============================================================================
// dec_pkg : shared encodings and instruction-field positions for the decode stage
// Rev 1.0
// ============================================================================
`default_nettype none

package dec_pkg;

    localparam int ADDR_W = 5;

    localparam int RS_LSB = 21;
    localparam int RD_LSB = 16;
    localparam int RT_LSB = 11;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,
        IMM_ZEXT = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_sel_e;

endpackage

`default_nettype wire

// File: rtl/dec_regfile.sv
// ============================================================================
// dec_regfile : 2 combinational read ports, 1 synchronous write port.
// Register 0 and addresses >= REG_CNT read as zero; writes to them are dropped.
// Rev 1.0
// ============================================================================
`default_nettype none

module dec_regfile
    import dec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    // Register 0 has no storage at all, so it cannot be written.
    logic [DATA_W-1:0] regs [1:REG_CNT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < REG_CNT; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 1; i < REG_CNT; i++) begin
            if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs[i];
            if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dec_stage_pipe.sv
// ============================================================================
// dec_stage_pipe : register file, write-back mux, immediate generation and the
// ID/EX pipeline register. Optional write-to-read bypass: DEC_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module dec_stage_pipe
    import dec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Instr,
    input  logic              Instr_valid,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              RF_B_sel,
    input  logic [1:0]        Imm_sel,
    input  logic              RF_WrEn,
    input  logic [ADDR_W-1:0] RF_WrAddr,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic              RF_WrData_sel,
    output logic [DATA_W-1:0] RF_A,
    output logic [DATA_W-1:0] RF_B,
    output logic [DATA_W-1:0] Immed,
    output logic [ADDR_W-1:0] Rd_out,
    output logic              Valid_out
);

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [15:0]       imm_field;
    logic              unused_opcode;

    assign rs_addr       = Instr[RS_LSB +: ADDR_W];
    assign rd_addr       = Instr[RD_LSB +: ADDR_W];
    assign rt_addr       = Instr[RT_LSB +: ADDR_W];
    assign b_addr        = RF_B_sel ? rd_addr : rt_addr;
    assign imm_field     = Instr[15:0];
    assign unused_opcode = ^Instr[31:26];

    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;

    dec_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk       (Clk),
        .rst       (Reset),
        .rd_addr_a (rs_addr),
        .rd_data_a (rd_a),
        .rd_addr_b (b_addr),
        .rd_data_b (rd_b),
        .wr_en     (RF_WrEn),
        .wr_addr   (RF_WrAddr),
        .wr_data   (wr_data)
    );

    // Extended to DATA_W+2 so the shifted modes truncate rather than wrap.
    logic [DATA_W+1:0] imm_sext;
    logic [DATA_W+1:0] imm_zext;
    logic [DATA_W-1:0] imm_next;

    assign imm_sext = {{(DATA_W-14){imm_field[15]}}, imm_field};
    assign imm_zext = {{(DATA_W-14){1'b0}}, imm_field};

    always_comb begin
        imm_next = DATA_W'(imm_sext);
        case (Imm_sel)
            IMM_SEXT: imm_next = DATA_W'(imm_sext);
            IMM_ZEXT: imm_next = DATA_W'(imm_zext);
            IMM_LUI:  imm_next = DATA_W'(imm_zext << 16);
            IMM_BR:   imm_next = DATA_W'(imm_sext << 2);
            default:  imm_next = DATA_W'(imm_sext);
        endcase
    end

    // cap_* is the value taken on a normal capture, hold_* the value kept while stalled.
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

`ifdef DEC_BYPASS_EN
    localparam logic [ADDR_W:0] REG_LIM = (ADDR_W+1)'(REG_CNT);

    logic              wr_ok;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;

    assign wr_ok  = RF_WrEn && (RF_WrAddr != '0) && ({1'b0, RF_WrAddr} < REG_LIM);
    assign cap_a  = (wr_ok && (RF_WrAddr == rs_addr)) ? wr_data : rd_a;
    assign cap_b  = (wr_ok && (RF_WrAddr == b_addr))  ? wr_data : rd_b;
    assign hold_a = (wr_ok && (RF_WrAddr == src_a))   ? wr_data : RF_A;
    assign hold_b = (wr_ok && (RF_WrAddr == src_b))   ? wr_data : RF_B;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            src_a <= '0;
            src_b <= '0;
        end else if (Flush) begin
            src_a <= '0;
            src_b <= '0;
        end else if (!Stall) begin
            src_a <= rs_addr;
            src_b <= b_addr;
        end
    end
`else
    assign cap_a  = rd_a;
    assign cap_b  = rd_b;
    assign hold_a = RF_A;
    assign hold_b = RF_B;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RF_A      <= '0;
            RF_B      <= '0;
            Immed     <= '0;
            Rd_out    <= '0;
            Valid_out <= 1'b0;
        end else if (Flush) begin
            RF_A      <= '0;
            RF_B      <= '0;
            Immed     <= '0;
            Rd_out    <= '0;
            Valid_out <= 1'b0;
        end else if (Stall) begin
            RF_A      <= hold_a;
            RF_B      <= hold_b;
        end else begin
            RF_A      <= cap_a;
            RF_B      <= cap_b;
            Immed     <= imm_next;
            Rd_out    <= rd_addr;
            Valid_out <= Instr_valid;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dec_stage_pipe.sv
// ============================================================================
// tb_dec_stage_pipe : directed plus randomized checks of dec_stage_pipe
// (DATA_W=32, REG_CNT=16) against a behavioural model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dec_stage_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        Instr_valid, Stall, Flush, RF_B_sel, RF_WrEn, RF_WrData_sel;
    logic [1:0]  Imm_sel;
    logic [4:0]  RF_WrAddr;
    logic [31:0] ALU_out, MEM_out;
    logic [31:0] RF_A, RF_B, Immed;
    logic [4:0]  Rd_out;
    logic        Valid_out;

    int total = 0;
    int bad   = 0;

    dec_stage_pipe #(.DATA_W(32), .REG_CNT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Instr_valid(Instr_valid),
        .Stall(Stall), .Flush(Flush), .RF_B_sel(RF_B_sel), .Imm_sel(Imm_sel),
        .RF_WrEn(RF_WrEn), .RF_WrAddr(RF_WrAddr), .ALU_out(ALU_out),
        .MEM_out(MEM_out), .RF_WrData_sel(RF_WrData_sel), .RF_A(RF_A),
        .RF_B(RF_B), .Immed(Immed), .Rd_out(Rd_out), .Valid_out(Valid_out)
    );

    always #5 Clk = ~Clk;

    // Reference model: architectural register contents plus expected ID/EX contents.
    logic [31:0] m_rf [32];
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_rd, m_src_a, m_src_b;
    logic        m_v;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (a != 5'd0 && a < 5'd16) ? m_rf[a] : 32'h0;
    endfunction

    function automatic logic [31:0] m_imm_of(input logic [15:0] imm, input logic [1:0] sel);
        logic signed [31:0] s;
        s = $signed(imm);
        case (sel)
            2'd0:    return s;
            2'd1:    return {16'h0, imm};
            2'd2:    return {imm, 16'h0};
            default: return s * 4;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rd, input logic [15:0] imm);
        return {6'b0, rs, rd, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_v = 0; m_src_a = 0; m_src_b = 0;
    endtask

    task automatic model_edge();
        logic [4:0]  rs, rd, ba;
        logic [31:0] wd;
        logic        wok;
        rs  = Instr[25:21];
        rd  = Instr[20:16];
        ba  = RF_B_sel ? rd : Instr[15:11];
        wd  = RF_WrData_sel ? MEM_out : ALU_out;
        wok = RF_WrEn && RF_WrAddr != 5'd0 && RF_WrAddr < 5'd16;
        if (Flush) begin
            m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_v = 0; m_src_a = 0; m_src_b = 0;
        end else if (Stall) begin
`ifdef DEC_BYPASS_EN
            if (wok && RF_WrAddr == m_src_a) m_a = wd;
            if (wok && RF_WrAddr == m_src_b) m_b = wd;
`endif
        end else begin
            m_a = m_read(rs);
            m_b = m_read(ba);
`ifdef DEC_BYPASS_EN
            if (wok && RF_WrAddr == rs) m_a = wd;
            if (wok && RF_WrAddr == ba) m_b = wd;
`endif
            m_imm = m_imm_of(Instr[15:0], Imm_sel);
            m_rd = rd; m_v = Instr_valid; m_src_a = rs; m_src_b = ba;
        end
        if (wok) m_rf[RF_WrAddr] = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".RF_A"}, RF_A, m_a);
        chk({tag, ".RF_B"}, RF_B, m_b);
        chk({tag, ".Immed"}, Immed, m_imm);
        chk({tag, ".Rd_out"}, {27'b0, Rd_out}, {27'b0, m_rd});
        chk({tag, ".Valid_out"}, {31'b0, Valid_out}, {31'b0, m_v});
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic iv,
                        input logic st, input logic fl, input logic bsel,
                        input logic [1:0] isel, input logic we, input logic [4:0] wa,
                        input logic [31:0] alu, input logic [31:0] mem, input logic wsel);
        Instr = ins; Instr_valid = iv; Stall = st; Flush = fl; RF_B_sel = bsel;
        Imm_sel = isel; RF_WrEn = we; RF_WrAddr = wa; ALU_out = alu;
        MEM_out = mem; RF_WrData_sel = wsel;
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        Instr = 0; Instr_valid = 0; Stall = 0; Flush = 0; RF_B_sel = 0; Imm_sel = 0;
        RF_WrEn = 0; RF_WrAddr = 0; ALU_out = 0; MEM_out = 0; RF_WrData_sel = 0;
        model_reset();
        #3;
        check_all("reset0");
        @(negedge Clk);
        Reset = 1'b0;

        step("wr_r1", 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'd7, 0, 0);
        step("wr_r2", 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'd5, 0, 0);
        step("rd12", mk(1, 0, 16'h1000), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle while Valid_out is high
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge Clk);
        Reset = 1'b0;

        step("rewr_r1", 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'd7, 0, 0);
        step("rewr_r2", 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'd5, 0, 0);

        step("cap_wr_r3", mk(3, 0, 0), 1, 0, 0, 0, 0, 1, 5'd3, 32'd99, 32'd12, 1);
        step("reread_r3", mk(3, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step("st_cap", mk(1, 4, 16'h1234), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("st1", mk(5, 6, 16'hFFFF), 1, 1, 0, 0, 2'd3, 1, 5'd1, 32'd9, 0, 0);
        step("st2", mk(5, 6, 16'hFFFF), 1, 1, 0, 0, 2'd3, 0, 0, 0, 0, 0);
        step("st3", mk(5, 6, 16'hFFFF), 1, 1, 0, 0, 2'd3, 0, 0, 0, 0, 0);
        step("st_rel", mk(1, 4, 16'h1234), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int s = 0; s < 4; s++) begin
            step($sformatf("imm%0d", s), mk(0, 0, 16'h8001), 1, 0, 0, 0, 2'(s), 0, 0, 0, 0, 0);
        end

        step("wr_r0", mk(0, 0, 0), 1, 0, 0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
        step("rd_r0", mk(0, 0, 0), 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        step("pre_flush", mk(1, 2, 16'h1000), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("flush_stall", mk(1, 2, 16'h1000), 1, 1, 1, 0, 0, 1, 5'd1, 32'd3, 0, 0);

        step("wr_r20", mk(20, 20, 0), 1, 0, 0, 1, 0, 1, 5'd20, 32'hAA, 0, 0);
        step("rd_r20", mk(20, 20, 0), 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0]  rs, rd, rt, wa;
            logic [15:0] imm;
            rs  = 5'($urandom_range(0, 19));
            rd  = 5'($urandom_range(0, 19));
            rt  = 5'($urandom_range(0, 19));
            wa  = 5'($urandom_range(0, 19));
            imm = {rt, 11'($urandom)};
            step($sformatf("rnd%0d", n), mk(rs, rd, imm), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 2'($urandom), 1'($urandom), wa,
                 $urandom, $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
